// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Round-robin arbiter sharing the regfile write port among NSrc
//            writeback sources, with a per-register busy scoreboard for
//            read-after-write stall detection. Optional macro RF_BYPASS_EN
//            forwards the in-flight write data to decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int XLen      = 32,
  parameter int NReg      = 32,
  parameter int NRegWidth = $clog2(NReg),
  parameter int NSrc      = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NSrc-1:0]           req_valid_i,
  input  logic [NSrc*NRegWidth-1:0] req_addr_i,
  input  logic [NSrc*XLen-1:0]      req_data_i,
  output logic [NSrc-1:0]           req_ready_o,
  input  logic                      alloc_i,
  input  logic [NRegWidth-1:0]      alloc_addr_i,
  input  logic [NRegWidth-1:0]      chk_a1_i,
  input  logic [NRegWidth-1:0]      chk_a2_i,
  output logic                      hazard_o,
  output logic                      byp1_o,
  output logic                      byp2_o,
  output logic [XLen-1:0]           byp_data_o,
  output logic                      rf_we_o,
  output logic [NRegWidth-1:0]      rf_waddr_o,
  output logic [XLen-1:0]           rf_wdata_o
);

  localparam int PtrW = $clog2(NSrc);

  logic [PtrW-1:0]      r_ptr;
  logic                 r_we;
  logic [NRegWidth-1:0] r_waddr;
  logic [XLen-1:0]      r_wdata;
  logic [NReg-1:0]      r_busy;

  logic                 w_gnt_any;
  logic [PtrW-1:0]      w_gnt_idx;
  logic [NRegWidth-1:0] w_sel_addr;
  logic [XLen-1:0]      w_sel_data;
  logic [NReg-1:0]      w_busy_nxt;
  logic                 w_byp1;
  logic                 w_byp2;

  // Scan sources starting at the rr pointer; the first valid one wins.
  always_comb begin
    int j;
    j          = 0;
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NSrc; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NSrc) j = j - NSrc;
      if (!w_gnt_any && req_valid_i[j]) begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = PtrW'(j);
        w_sel_addr = req_addr_i[j*NRegWidth +: NRegWidth];
        w_sel_data = req_data_i[j*XLen +: XLen];
      end
    end
  end

  for (genvar s = 0; s < NSrc; s++) begin : g_ready
    assign req_ready_o[s] = rst_ni & w_gnt_any & (w_gnt_idx == PtrW'(s));
  end

  // A new allocation on the retiring edge wins over the clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) w_busy_nxt[r_waddr] = 1'b0;
    if (alloc_i && (alloc_addr_i != '0)) w_busy_nxt[alloc_addr_i] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_gnt_any && (w_sel_addr != '0);
      if (w_gnt_any) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
        r_ptr   <= (w_gnt_idx == PtrW'(NSrc - 1)) ? '0 : w_gnt_idx + PtrW'(1);
      end
    end
  end

`ifdef RF_BYPASS_EN
  if (1) begin : g_bypass
    assign w_byp1 = r_we & (r_waddr == chk_a1_i) & (chk_a1_i != '0);
    assign w_byp2 = r_we & (r_waddr == chk_a2_i) & (chk_a2_i != '0);
  end
`else
  if (1) begin : g_no_bypass
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
  end
`endif

  assign byp1_o     = w_byp1;
  assign byp2_o     = w_byp2;
  assign hazard_o   = (r_busy[chk_a1_i] & ~w_byp1) | (r_busy[chk_a2_i] & ~w_byp2);
  assign byp_data_o = r_wdata;
  assign rf_we_o    = r_we;
  assign rf_waddr_o = r_waddr;
  assign rf_wdata_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Scoreboard bench for rf_wb_arbiter: expected writes are queued
//            by the stimulus and retired by an independent write-port monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int XLen = 32;
  localparam int NRegWidth = 5;
  localparam int NSrc = 3;

  logic                      clk;
  logic                      rst_ni;
  logic [NSrc-1:0]           req_valid;
  logic [NSrc*NRegWidth-1:0] req_addr;
  logic [NSrc*XLen-1:0]      req_data;
  logic [NSrc-1:0]           req_ready;
  logic                      alloc;
  logic [NRegWidth-1:0]      alloc_addr;
  logic [NRegWidth-1:0]      chk_a1;
  logic [NRegWidth-1:0]      chk_a2;
  logic                      hazard;
  logic                      byp1;
  logic                      byp2;
  logic [XLen-1:0]           byp_data;
  logic                      rf_we;
  logic [NRegWidth-1:0]      rf_waddr;
  logic [XLen-1:0]           rf_wdata;

  typedef struct {
    logic [NRegWidth-1:0] a;
    logic [XLen-1:0]      d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_wb_arbiter #(.XLen(XLen), .NReg(32), .NSrc(NSrc)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .alloc_i      (alloc),
    .alloc_addr_i (alloc_addr),
    .chk_a1_i     (chk_a1),
    .chk_a2_i     (chk_a2),
    .hazard_o     (hazard),
    .byp1_o       (byp1),
    .byp2_o       (byp2),
    .byp_data_o   (byp_data),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int s, input logic [NRegWidth-1:0] a, input logic [XLen-1:0] d);
    req_addr[s*NRegWidth +: NRegWidth] = a;
    req_data[s*XLen +: XLen] = d;
    req_valid[s] = 1'b1;
  endtask

  task automatic expect_wr(input logic [NRegWidth-1:0] a, input logic [XLen-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Write-port monitor: every rf_we_o cycle must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_ni && rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_waddr}, 64'hFFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {59'd0, rf_waddr}, {59'd0, w.a});
        check("wr_data", {32'd0, rf_wdata}, {32'd0, w.d});
      end
    end
  end

  logic [NRegWidth-1:0] t2_addr [4];
  logic [NSrc-1:0]      t2_gnt  [4];

  initial begin
    rst_ni = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    alloc = 1'b0; alloc_addr = '0; chk_a1 = '0; chk_a2 = '0;

    // 1: reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = NSrc'($urandom); req_addr = NSrc*NRegWidth'($urandom);
      req_data = {$urandom, $urandom, $urandom};
      alloc = 1'($urandom); alloc_addr = NRegWidth'($urandom);
      chk_a1 = NRegWidth'($urandom); chk_a2 = NRegWidth'($urandom);
      #1;
      check("rst_we", {63'd0, rf_we}, 64'd0);
      check("rst_ready", {61'd0, req_ready}, 64'd0);
      check("rst_hazard", {63'd0, hazard}, 64'd0);
    end
    @(negedge clk);
    req_valid = '0; alloc = 1'b0;
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_a1 = NRegWidth'($urandom); chk_a2 = NRegWidth'($urandom);
      #1 check("post_rst_hazard", {63'd0, hazard}, 64'd0);
    end

    // 2: all sources valid, rotate s0,s1,s2,s0
    t2_addr[0] = 5; t2_addr[1] = 6; t2_addr[2] = 7; t2_addr[3] = 5;
    t2_gnt[0] = 3'b001; t2_gnt[1] = 3'b010; t2_gnt[2] = 3'b100; t2_gnt[3] = 3'b001;
    @(negedge clk);
    chk_a1 = 0; chk_a2 = 0;
    set_src(0, 5, 32'h0000_0A05); set_src(1, 6, 32'h0000_0B06); set_src(2, 7, 32'h0000_0C07);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("rr_grant", {61'd0, req_ready}, {61'd0, t2_gnt[k]});
      expect_wr(t2_addr[k], (k % 3 == 0) ? 32'h0A05 : (k == 1) ? 32'h0B06 : 32'h0C07);
      if (k > 0) check("rr_latency_addr", {59'd0, rf_waddr}, {59'd0, t2_addr[k-1]});
    end
    @(negedge clk);
    req_valid = '0;
    #1 check("idle_ready", {61'd0, req_ready}, 64'd0);

    // 3: alloc x9, s1 writes it; decode watches x9
    @(negedge clk);
    alloc = 1'b1; alloc_addr = 9; chk_a1 = 9;
    #1 check("t3_pre_alloc_hazard", {63'd0, hazard}, 64'd0);
    @(negedge clk);
    alloc = 1'b0; set_src(1, 9, 32'hDEAD_BEEF);
    #1;
    check("t3_busy_hazard", {63'd0, hazard}, 64'd1);
    check("t3_grant", {61'd0, req_ready}, 64'b010);
    expect_wr(9, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("t3_wr_cycle_hazard", {63'd0, hazard}, BYP ? 64'd0 : 64'd1);
    check("t3_byp1", {63'd0, byp1}, {63'd0, BYP});
    check("t3_byp_data", {32'd0, byp_data}, 64'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("t3_after_hazard", {63'd0, hazard}, 64'd0);
    check("t3_after_byp1", {63'd0, byp1}, 64'd0);

    // 4: write to x0 and alloc x0
    @(negedge clk);
    set_src(0, 0, 32'h0000_1234); alloc = 1'b1; alloc_addr = 0; chk_a1 = 0; chk_a2 = 0;
    #1;
    check("t4_grant", {61'd0, req_ready}, 64'b001);
    check("t4_hazard", {63'd0, hazard}, 64'd0);
    @(negedge clk);
    req_valid = '0; alloc = 1'b0;
    #1;
    check("t4_no_we", {63'd0, rf_we}, 64'd0);
    check("t4_hazard_after", {63'd0, hazard}, 64'd0);

    // 5: re-alloc x3 on the edge its write retires
    @(negedge clk);
    alloc = 1'b1; alloc_addr = 3;
    @(negedge clk);
    alloc = 1'b0; chk_a1 = 3; set_src(2, 3, 32'h0000_0033);
    #1;
    check("t5_hazard", {63'd0, hazard}, 64'd1);
    check("t5_grant", {61'd0, req_ready}, 64'b100);
    expect_wr(3, 32'h0000_0033);
    @(negedge clk);
    req_valid = '0; alloc = 1'b1; alloc_addr = 3;
    #1 check("t5_wr_cycle_hazard", {63'd0, hazard}, BYP ? 64'd0 : 64'd1);
    @(negedge clk);
    alloc = 1'b0;
    #1 check("t5_set_wins_a1", {63'd0, hazard}, 64'd1);
    chk_a1 = 0; chk_a2 = 3;
    #1 check("t5_set_wins_a2", {63'd0, hazard}, 64'd1);

    // 6: reset while a write is in flight
    @(negedge clk);
    chk_a2 = 0; alloc = 1'b1; alloc_addr = 12;
    @(negedge clk);
    alloc = 1'b0; chk_a1 = 12; set_src(1, 4, 32'h0000_0044);
    #1 check("t6_grant", {61'd0, req_ready}, 64'b010);
    @(posedge clk);
    #2;
    check("t6_inflight_we", {63'd0, rf_we}, 64'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_we", {63'd0, rf_we}, 64'd0);
    check("t6_rst_waddr", {59'd0, rf_waddr}, 64'd0);
    check("t6_rst_busy", {63'd0, hazard}, 64'd0);
    check("t6_rst_ready", {61'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    set_src(0, 1, 32'h11); set_src(1, 2, 32'h22); set_src(2, 3, 32'h33);
    #1;
    check("t6_ptr_restart", {61'd0, req_ready}, 64'b001);
    check("t6_busy_cleared", {63'd0, hazard}, 64'd0);
    expect_wr(1, 32'h11);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
